// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive control path.
package uart_pkg;

  localparam int unsigned ByteW         = 8;
  // About one 10-bit frame at 50 MHz / 115200 baud, plus margin.
  localparam int unsigned DefTimeoutCyc = 5000;

  localparam logic [1:0] StateOff     = 2'd0;
  localparam logic [1:0] StateRun     = 2'd1;
  localparam logic [1:0] StateRecover = 2'd2;

  typedef enum logic [1:0] {
    StOff     = StateOff,
    StRun     = StateRun,
    StRecover = StateRecover
  } ctrl_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead circular byte FIFO; dout reads 0 while empty, drop flags a rejected push.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ByteW-1:0]       din,
  output logic [ByteW-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic [ByteW-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PtrW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign level   = cnt_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (PtrW + 1)'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver control: enable FSM, frame capture into the FIFO, error statistics.
// Optional watchdog recovery is built when UART_RX_CTRL_WATCHDOG_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clr_stat,
  output logic                   rxEn,
  input  logic                   rxBusy,
  input  logic                   rxDone,
  input  logic [ByteW-1:0]       rx_data,
  input  logic                   rx_right,
  input  logic                   rd_en,
  output logic [ByteW-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             err_cnt,
  output logic [7:0]             timeout_cnt
);

  localparam int unsigned RcW = $clog2(RECOVER_CYC) + 1;

  ctrl_state_e    state_q;
  logic           rx_en_q;
  logic [RcW-1:0] rec_cnt_q;
  logic           done_q;
  logic           frame_evt, fifo_push, fifo_drop, wd_hit;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic           overflow_q, overflow_d;

  assign rxEn      = rx_en_q;
  assign frame_evt = rxDone & ~done_q & (state_q == StRun);
  assign fifo_push = frame_evt & rx_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOff;
      rx_en_q   <= 1'b0;
      rec_cnt_q <= '0;
    end else if (!enable) begin
      state_q   <= StOff;
      rx_en_q   <= 1'b0;
      rec_cnt_q <= '0;
    end else begin
      case (state_q)
        StOff: begin
          state_q <= StRun;
          rx_en_q <= 1'b1;
        end
        StRun: begin
          if (wd_hit) begin
            state_q   <= StRecover;
            rx_en_q   <= 1'b0;
            rec_cnt_q <= '0;
          end
        end
        StRecover: begin
          if (rec_cnt_q == RcW'(RECOVER_CYC - 1)) begin
            state_q <= StRun;
            rx_en_q <= 1'b1;
          end else begin
            rec_cnt_q <= rec_cnt_q + RcW'(1);
          end
        end
        default: begin
          state_q <= StOff;
          rx_en_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_CTRL_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC) + 1;

  logic [WdW-1:0] wd_cnt_q;
  logic [7:0]     tmo_cnt_q, tmo_cnt_d;

  // Fires on the TIMEOUT_CYC-th consecutive busy cycle in RUN.
  assign wd_hit = (state_q == StRun) && rxBusy && (wd_cnt_q == WdW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if ((state_q != StRun) || !rxBusy || wd_hit) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + WdW'(1);
    end
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (clr_stat) begin
      tmo_cnt_d = '0;
    end else if (wd_hit && (tmo_cnt_q != 8'hFF)) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout_cnt = tmo_cnt_q;
`else
  logic unused_wd;

  assign wd_hit      = 1'b0;
  assign timeout_cnt = '0;
  assign unused_wd   = rxBusy ^ (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    err_cnt_d  = err_cnt_q;
    overflow_d = overflow_q;
    if (clr_stat) begin
      err_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (frame_evt && !rx_right && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      if (fifo_drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q     <= rxDone;
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign overflow = overflow_q;

  uart_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .pop  (rd_en),
    .din  (rx_data),
    .dout (rd_data),
    .empty(empty),
    .full (full),
    .level(level),
    .drop (fifo_drop)
  );

endmodule
